comparator_pipelined: RTL

Parametrised, pipelined magnitude comparator; successor to the fixed 8-bit combinational comparator. Compares two WIDTH-bit operands in CHUNK-bit slices, MSB slice first, one slice per pipeline stage. Supports a per-transaction signed/unsigned mode and a valid/ready handshake with backpressure. Sits in the arithmetic library as a drop-in for wide datapaths where a single-cycle compare misses timing.

---
 rtl/comparator_pkg.sv | 19 +
 rtl/comparator_pipe_stage.sv | 91 +++++++++
 rtl/comparator_pipelined.sv | 103 ++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the pipelined magnitude comparator: per-stage decision state
// and its mapping onto the {gt, eq, lt} result lines.
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_state_t;

    function automatic logic [2:0] cmp_onehot(input cmp_state_t s);
        case (s)
            CMP_GT:  return 3'b100;
            CMP_LT:  return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/comparator_pipe_stage.sv
// One comparator pipeline slice: compares the top CHUNK bits of the remaining
// operands, folds the result into the running decision, and registers it.
module comparator_pipe_stage
    import comparator_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter int TAG_W = 4,
    parameter int REM_W = 24,
    parameter bit FIRST = 1'b0,
    localparam int IN_W  = REM_W + CHUNK,
    localparam int REG_W = (REM_W > 0) ? REM_W : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       state_i,
    input  logic             signed_i,
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [1:0]       state_o,
    output logic             signed_o,
    output logic [REG_W-1:0] a_o,
    output logic [REG_W-1:0] b_o,
    output logic [TAG_W-1:0] tag_o
);

    cmp_state_t       state_q, state_d, prior;
    logic             valid_q, signed_q;
    logic [TAG_W-1:0] tag_q;
    logic [CHUNK-1:0] a_sl, b_sl, flip;

    // Flipping the sign bit of the MSB slice turns a signed compare into an unsigned one.
    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = FIRST && signed_i;
        a_sl            = a_i[IN_W-1 -: CHUNK] ^ flip;
        b_sl            = b_i[IN_W-1 -: CHUNK] ^ flip;
        prior           = cmp_state_t'(state_i);
        state_d         = prior;
        if (prior == CMP_EQ) begin
            if (a_sl > b_sl)      state_d = CMP_GT;
            else if (a_sl < b_sl) state_d = CMP_LT;
        end
    end

    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            state_q  <= CMP_EQ;
            signed_q <= 1'b0;
            tag_q    <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                state_q  <= state_d;
                signed_q <= signed_i;
                tag_q    <= tag_i;
            end
        end
    end

    if (REM_W > 0) begin : g_rem
        logic [REG_W-1:0] a_q, b_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                a_q <= '0;
                b_q <= '0;
            end else if (ready_o && valid_i) begin
                a_q <= a_i[REM_W-1:0];
                b_q <= b_i[REM_W-1:0];
            end
        end
        assign a_o = a_q;
        assign b_o = b_q;
    end else begin : g_norem
        assign a_o = '0;
        assign b_o = '0;
    end

    assign valid_o  = valid_q;
    assign state_o  = state_q;
    assign signed_o = signed_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/comparator_pipelined.sv
// Pipelined WIDTH-bit magnitude comparator, one CHUNK-bit slice per stage
// (MSB first), with valid/ready flow control and a pass-through tag.
module comparator_pipelined
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Enable_In,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Signed_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    input  logic [TAG_W-1:0] Tag_In,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             A_gt_B_Out,
    output logic             A_eq_B_Out,
    output logic             A_lt_B_Out,
    output logic [TAG_W-1:0] Tag_Out
);

    localparam int STAGES = (CHUNK > 0) ? WIDTH / CHUNK : 1;

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK > 0) ? CHUNK : 1)) != 0)) begin : g_param_check
        $error("comparator_pipelined: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = WIDTH - k * CHUNK;
        localparam int REM_W = IN_W - CHUNK;
        localparam int REG_W = (REM_W > 0) ? REM_W : 1;

        logic             vin, rdy, rdy_dn, vout, sgn_in, sgn_out;
        logic [1:0]       st_in, st_out;
        logic [IN_W-1:0]  a_in, b_in;
        logic [REG_W-1:0] a_out, b_out;
        logic [TAG_W-1:0] tag_in, tag_out;

        if (k == 0) begin : g_head
            assign vin    = In_Valid && Enable_In;
            assign st_in  = CMP_EQ;
            assign sgn_in = Signed_In;
            assign a_in   = Data_A_In;
            assign b_in   = Data_B_In;
            assign tag_in = Tag_In;
        end else begin : g_link
            assign vin    = g_stage[k-1].vout;
            assign st_in  = g_stage[k-1].st_out;
            assign sgn_in = g_stage[k-1].sgn_out;
            assign a_in   = g_stage[k-1].a_out;
            assign b_in   = g_stage[k-1].b_out;
            assign tag_in = g_stage[k-1].tag_out;
        end

        if (k == STAGES - 1) begin : g_tail
            logic ops_unused;
            assign rdy_dn     = Out_Ready;
            assign ops_unused = ^{a_out, b_out, sgn_out};
        end else begin : g_mid
            assign rdy_dn = g_stage[k+1].rdy;
        end

        comparator_pipe_stage #(
            .CHUNK (CHUNK),
            .TAG_W (TAG_W),
            .REM_W (REM_W),
            .FIRST (k == 0)
        ) u_stage (
            .clk_i    (Clk_In),
            .rst_i    (Reset_In),
            .valid_i  (vin),
            .ready_o  (rdy),
            .state_i  (st_in),
            .signed_i (sgn_in),
            .a_i      (a_in),
            .b_i      (b_in),
            .tag_i    (tag_in),
            .valid_o  (vout),
            .ready_i  (rdy_dn),
            .state_o  (st_out),
            .signed_o (sgn_out),
            .a_o      (a_out),
            .b_o      (b_out),
            .tag_o    (tag_out)
        );
    end

    logic [2:0] res;
    assign res       = cmp_onehot(cmp_state_t'(g_stage[STAGES-1].st_out));
    assign Out_Valid = g_stage[STAGES-1].vout;
    assign Tag_Out   = g_stage[STAGES-1].tag_out;
    assign In_Ready  = Enable_In && g_stage[0].rdy;

    // Result lines are forced low between results.
    assign {A_gt_B_Out, A_eq_B_Out, A_lt_B_Out} = Out_Valid ? res : 3'b000;

endmodule
